// File: rtl/wb_mem_slave_pkg.sv
// rtl/wb_mem_slave_pkg.sv - shared widths and FSM state encoding for the memory slave
// Purpose: single place for the bus widths the cache controller, MSHR and this
//          slave agree on, plus the 2-bit FSM state encoding and counter width.
// Ports:   none (package).
package wb_mem_slave_pkg;

  localparam int WB_ADDR_W   = 8;
  localparam int WB_DATA_W   = 32;

  // Wait-state counter width; LATENCY must fit in it.
  localparam int CNT_W       = 4;
  localparam int LATENCY_MAX = 15;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_WAIT = 2'd1;
  localparam state_t ST_RESP = 2'd2;
  localparam state_t ST_HOLD = 2'd3;

endpackage

// File: rtl/wb_mem_slave_ram.sv
// rtl/wb_mem_slave_ram.sv - single-port DEPTH x DATA_W array, sync write, async read
// Purpose: backing store for the memory slave. Not cleared by reset.
// Ports:
//   clk    in   system clock, rising edge
//   we     in   write enable, sampled on the rising edge
//   addr   in   word index
//   wdata  in   write data
//   rdata  out  read data, combinational from addr
module sp_ram
  import wb_mem_slave_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int DATA_W = WB_DATA_W,
  parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/wb_mem_slave.sv
// rtl/wb_mem_slave.sv - word-addressed memory slave with programmable wait states
// Purpose: accepts one cyc/we/adr/dat request, waits LATENCY cycles, then returns
//          a one-cycle ack (with read data) or err for out-of-range addresses.
//          Dropping cyc_i before the response aborts the transfer without effect.
// Ports:
//   clk    in   system clock, rising edge
//   rst    in   synchronous active-high reset
//   cyc_i  in   request valid
//   we_i   in   1 = write, 0 = read
//   adr_i  in   word address
//   dat_i  in   write data
//   dat_o  out  registered read data, zero outside the response cycle
//   ack_o  out  registered one-cycle completion pulse
//   err_o  out  registered one-cycle out-of-range pulse
module wb_mem_slave
  import wb_mem_slave_pkg::*;
#(
  parameter int ADDR_W  = WB_ADDR_W,
  parameter int DATA_W  = WB_DATA_W,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cyc_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] adr_i,
  input  logic [DATA_W-1:0] dat_i,
  output logic [DATA_W-1:0] dat_o,
  output logic              ack_o,
  output logic              err_o
);

  localparam int               RAM_AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] LAT_CNT  = CNT_W'(LATENCY);
  // With no wait states the captured request goes straight to the response.
  localparam state_t           FIRST_ST = (LATENCY > 0) ? ST_WAIT : ST_RESP;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic [ADDR_W-1:0] adr_q,   adr_d;
  logic              we_q,    we_d;
  logic [DATA_W-1:0] wdat_q,  wdat_d;
  logic              ack_q,   ack_d;
  logic              err_q,   err_d;
  logic [DATA_W-1:0] dat_q,   dat_d;

  logic              in_range;
  logic              resp_go;
  logic              ram_we;
  logic [DATA_W-1:0] ram_rdata;

  // Full-width compare so addresses that alias onto the array index are still rejected.
  assign in_range = 32'(adr_q) < 32'(DEPTH);
  // The response edge only takes effect if the master is still holding cyc.
  assign resp_go  = (state_q == ST_RESP) && cyc_i;
  assign ram_we   = resp_go && in_range && we_q && !rst;

  sp_ram #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .AW     (RAM_AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (adr_q[RAM_AW-1:0]),
    .wdata (wdat_q),
    .rdata (ram_rdata)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      adr_q   <= '0;
      we_q    <= 1'b0;
      wdat_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      we_q    <= we_d;
      wdat_q  <= wdat_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      dat_q   <= dat_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    we_d    = we_q;
    wdat_d  = wdat_q;
    case (state_q)
      ST_IDLE: begin
        if (cyc_i) begin
          adr_d   = adr_i;
          we_d    = we_i;
          wdat_d  = dat_i;
          cnt_d   = LAT_CNT;
          state_d = FIRST_ST;
        end
      end
      ST_WAIT: begin
        if (!cyc_i) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        state_d = cyc_i ? ST_HOLD : ST_IDLE;
      end
      ST_HOLD: begin
        // A held cyc is the tail of the finished transfer, never a new request.
        if (!cyc_i) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output logic (registered by the state register process)
  always_comb begin
    ack_d = 1'b0;
    err_d = 1'b0;
    dat_d = '0;
    if (resp_go) begin
      if (in_range) begin
        ack_d = 1'b1;
        if (!we_q) begin
          dat_d = ram_rdata;
        end
      end else begin
        err_d = 1'b1;
      end
    end
  end

  assign dat_o = dat_q;
  assign ack_o = ack_q;
  assign err_o = err_q;

  latency_range_a : assert property (@(posedge clk) (LATENCY >= 0) && (LATENCY <= LATENCY_MAX))
    else $error("wb_mem_slave: LATENCY %0d outside 0..%0d", LATENCY, LATENCY_MAX);

endmodule

// File: doc/wb_mem_slave.md
Name: wb_mem_slave

Overview:
- Word-addressed memory slave that sits directly downstream of the cache controller's memory port.
- Consumes the controller's cyc/we/adr/dat request and returns read data plus ack, or err, after a programmable number of wait states.
- Serves as the backing store for cache fills, write-through and LRU write-back traffic in simulation and on FPGA.

Parameters:
- ADDR_W, 8, address width in words
- DATA_W, 32, data word width
- DEPTH, 256, number of implemented words; addresses >= DEPTH are out of range
- LATENCY, 2, wait states between request capture and response; legal range 0..15

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset
- cyc_i  in  1  request valid from controller (cyc_m2s)
- we_i  in  1  1 = write, 0 = read (we_m2s)
- adr_i  in  ADDR_W  word address (adr_m2s)
- dat_i  in  DATA_W  write data (dat_m2s)
- dat_o  out  DATA_W  read data to controller (dat_mem_i)
- ack_o  out  1  transfer complete, one-cycle pulse (ack_mem_i)
- err_o  out  1  out-of-range address, one-cycle pulse

Behaviour:
- Clocking and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: ack_o=0, err_o=0, dat_o=0, state=IDLE, wait counter=0. The memory array is not cleared by reset.
- All outputs are registered. No combinational path from any input to any output.
- FSM states: IDLE, WAIT, RESP, HOLD.
- IDLE:
  - When cyc_i=1 at an edge, latch adr_i, we_i and dat_i, and load counter=LATENCY.
  - Next state is WAIT if LATENCY>0, else RESP.
- WAIT:
  - Counter decrements each edge. Leave for RESP on the edge where the counter reaches 0.
  - If cyc_i=0 at any WAIT edge: abort to IDLE. No write, no ack, no err.
  - Changes on adr_i, we_i or dat_i after capture are ignored.
- RESP (entered for one edge):
  - In range, write: commit the latched data to mem[adr]. ack_o=1.
  - In range, read: dat_o=mem[adr], ack_o=1.
  - Out of range (adr >= DEPTH): err_o=1, ack_o=0, no write, dat_o=0.
  - The abort rule applies here too: cyc_i=0 at this edge -> IDLE with no commit and no response.
  - Next state: HOLD.
- HOLD:
  - ack_o/err_o return to 0 and dat_o returns to 0 on the following edge.
  - Stay in HOLD while cyc_i=1. Go to IDLE when cyc_i=0.
  - The controller must drop cyc_i for at least one cycle between transactions. This prevents a held cyc from being taken as a second request.
- Latency: request sampled at edge E0; ack_o/err_o is high in the cycle after edge E0+LATENCY+1. LATENCY=0 gives ack one cycle after capture, i.e. a 2-cycle round trip.
- ack_o and err_o are never high together. Each pulses for exactly one cycle per accepted transaction.
- Reset mid-operation (WAIT or RESP): return to IDLE; no write commits; outputs are 0 on the next cycle.
- Read-after-write to the same address in consecutive transactions returns the new data.
- Counter width is 4 bits. LATENCY outside 0..15 is a configuration error and is flagged by a simulation-only assertion.

Decomposition:
- Shared package/header holds:
  - FSM state encoding (2-bit localparams, same style as the controller's states)
  - default ADDR_W/DATA_W, so controller, MSHR and this slave agree on widths
- One sub-module, sp_ram: single-port DEPTH x DATA_W array with synchronous write enable and asynchronous read. wb_mem_slave registers the read result into dat_o.

Test Plan:
- LATENCY=2: write adr=0x10 dat=0xDEADBEEF, then after cyc drops, read adr=0x10 -> ack_o high exactly 3 cycles after each capture; read returns dat_o=0xDEADBEEF; err_o stays 0.
- LATENCY=0: back-to-back writes 0x01->0x11111111 and 0x02->0x22222222, each followed by a one-cycle cyc gap, then read both -> 2-cycle round trip each; data returned in order.
- DEPTH=256, ADDR_W=9: write adr=0x1FF -> err_o=1 for one cycle, ack_o=0; a subsequent read of adr=0x0FF still returns its prior value.
- Abort: start write adr=0x20 dat=0x12345678 with LATENCY=4, drop cyc_i after 2 cycles -> no ack/err; later read of 0x20 returns its old value (0xAAAAAAAA preloaded).
- Reset mid-WAIT: write adr=0x30 dat=0xCAFEF00D, assert rst for 1 cycle during WAIT -> outputs 0, state IDLE, mem[0x30] unchanged on readback.
- Hold cyc_i high 5 cycles after ack -> exactly one ack pulse; a new request is accepted only after cyc_i goes low then high again.
